// File: rtl/gt_pkg.sv
// Shared definitions for the GT link watchdog and its status register map.
// Holds the state encoding, the retry counter width and a saturating increment helper.
package gt_pkg;

    localparam int unsigned StateWidth = 3;
    localparam int unsigned RetryWidth = 8;

    // Encoding is visible on the state status output; keep values stable.
    typedef enum logic [StateWidth-1:0] {
        StIdle      = 3'd0,
        StReq       = 3'd1,
        StWaitDone  = 3'd2,
        StWaitAlign = 3'd3,
        StUp        = 3'd4,
        StBackoff   = 3'd5,
        StFail      = 3'd6
    } gt_state_e;

    function automatic logic [RetryWidth-1:0] retry_inc(input logic [RetryWidth-1:0] v);
        return (v == '1) ? v : v + RetryWidth'(1);
    endfunction

endpackage

// File: rtl/gt_link_watchdog_if.sv
// Status/control bundle between the GT link watchdog and its surroundings.
//   slave  : the watchdog (consumes start/sequencer status/aligned, drives request and status)
//   master : the environment (sequencer, link logic, status register)
interface gt_link_watchdog_if;
    import gt_pkg::*;

    logic                  start;
    logic                  resetdone;
    logic                  resetdonestrobe;
    logic                  aligned;
    logic                  resetreq;
    logic                  linkup;
    logic                  linkupstrobe;
    logic                  failed;
    logic [RetryWidth-1:0] retrycnt;
    logic [StateWidth-1:0] state;

    modport slave (
        input  start, resetdone, resetdonestrobe, aligned,
        output resetreq, linkup, linkupstrobe, failed, retrycnt, state
    );

    modport master (
        output start, resetdone, resetdonestrobe, aligned,
        input  resetreq, linkup, linkupstrobe, failed, retrycnt, state
    );

endinterface

// File: rtl/gt_link_runcnt.sv
// Saturating run/timer counter with synchronous clear and count enable.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : force count to zero next cycle (wins over en_i)
//   en_i          : count this cycle
//   term_i        : terminal count
//   hit_o         : this enabled cycle brings the count to term_i
module gt_link_runcnt #(
    parameter int unsigned CNTWIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [CNTWIDTH-1:0] term_i,
    output logic                hit_o
);

    logic [CNTWIDTH-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNTWIDTH'(1);

    // Independent of clr_i so the FSM can use it to choose its next state.
    assign hit_o = en_i && (cnt_inc == term_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gt_link_watchdog.sv
// GT link bring-up watchdog: drives the reset sequencer request, waits for its done strobe,
// qualifies link alignment, declares link-up and retries with backoff on timeout or loss.
//   stableclk : free-running stable clock
//   resetn    : asynchronous active-low reset
//   bus_io    : start/resetdone/resetdonestrobe/aligned in;
//               resetreq/linkup/linkupstrobe/failed/retrycnt/state out (all registered)
module gt_link_watchdog
    import gt_pkg::*;
#(
    parameter int unsigned REQLENGTH    = 4,
    parameter int unsigned DONETIMEOUT  = 65535,
    parameter int unsigned ALIGNTIMEOUT = 65535,
    parameter int unsigned STABLELENGTH = 1024,
    parameter int unsigned LOSSLENGTH   = 16,
    parameter int unsigned BACKOFF      = 4096,
    parameter int unsigned MAXRETRY     = 8,
    parameter int unsigned CNTWIDTH     = 16
) (
    input  logic               stableclk,
    input  logic               resetn,
    gt_link_watchdog_if.slave  bus_io
);

    localparam logic [CNTWIDTH-1:0]   ReqTerm     = CNTWIDTH'(REQLENGTH);
    localparam logic [CNTWIDTH-1:0]   DoneTerm    = CNTWIDTH'(DONETIMEOUT);
    localparam logic [CNTWIDTH-1:0]   AlignTerm   = CNTWIDTH'(ALIGNTIMEOUT);
    localparam logic [CNTWIDTH-1:0]   StableTerm  = CNTWIDTH'(STABLELENGTH);
    localparam logic [CNTWIDTH-1:0]   LossTerm    = CNTWIDTH'(LOSSLENGTH);
    localparam logic [CNTWIDTH-1:0]   BackoffTerm = CNTWIDTH'(BACKOFF);
    localparam logic [RetryWidth-1:0] MaxRetry    = RetryWidth'(MAXRETRY);

    gt_state_e             state_q, state_d;
    logic [RetryWidth-1:0] retry_q, retry_d;
    logic                  start_q;
    logic                  resetreq_q, linkup_q, linkupstrobe_q, failed_q;

    logic                  timer_clr, timer_hit;
    logic [CNTWIDTH-1:0]   timer_term;
    logic                  run_clr, run_en, run_hit;
    logic                  loss_clr, loss_en, loss_hit;
    logic                  retry_now;

    // Terminal count for the shared state timer depends on which state is being timed.
    always_comb begin
        timer_term = ReqTerm;
        case (state_q)
            StWaitDone:  timer_term = DoneTerm;
            StWaitAlign: timer_term = AlignTerm;
            StBackoff:   timer_term = BackoffTerm;
            default:     timer_term = ReqTerm;
        endcase
    end

    gt_link_runcnt #(
        .CNTWIDTH (CNTWIDTH)
    ) u_timer (
        .clk_i  (stableclk),
        .rst_ni (resetn),
        .clr_i  (timer_clr),
        .en_i   (1'b1),
        .term_i (timer_term),
        .hit_o  (timer_hit)
    );

    assign run_en  = (state_q == StWaitAlign) && bus_io.aligned;
    assign run_clr = (state_q != StWaitAlign) || !bus_io.aligned;

    gt_link_runcnt #(
        .CNTWIDTH (CNTWIDTH)
    ) u_run (
        .clk_i  (stableclk),
        .rst_ni (resetn),
        .clr_i  (run_clr),
        .en_i   (run_en),
        .term_i (StableTerm),
        .hit_o  (run_hit)
    );

    assign loss_en  = (state_q == StUp) && !bus_io.aligned;
    assign loss_clr = (state_q != StUp) || bus_io.aligned;

    gt_link_runcnt #(
        .CNTWIDTH (CNTWIDTH)
    ) u_loss (
        .clk_i  (stableclk),
        .rst_ni (resetn),
        .clr_i  (loss_clr),
        .en_i   (loss_en),
        .term_i (LossTerm),
        .hit_o  (loss_hit)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        retry_now = 1'b0;
        timer_clr = 1'b0;

        if (start_q) begin
            // A (re)start overrides any same-cycle timeout, loss or strobe.
            state_d   = StReq;
            retry_d   = '0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                StIdle: ;
                StReq: begin
                    if (timer_hit) state_d = StWaitDone;
                end
                StWaitDone: begin
                    // Only the strobe counts; the done level may be stale from a prior attempt.
                    if (bus_io.resetdonestrobe) state_d = StWaitAlign;
                    else if (timer_hit)         retry_now = 1'b1;
                end
                StWaitAlign: begin
                    if (run_hit) begin
                        state_d = StUp;
                        retry_d = '0;
                    end else if (timer_hit) begin
                        retry_now = 1'b1;
                    end
                end
                StUp: begin
                    if (loss_hit) retry_now = 1'b1;
                end
                StBackoff: begin
                    if (timer_hit) state_d = StReq;
                end
                StFail: ;
                default: state_d = StIdle;
            endcase

            if (retry_now) begin
                if (retry_q == MaxRetry) begin
                    state_d = StFail;
                end else begin
                    state_d = StBackoff;
                    retry_d = retry_inc(retry_q);
                end
            end
        end

        if (state_d != state_q) timer_clr = 1'b1;
    end

    always_ff @(posedge stableclk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            retry_q        <= '0;
            start_q        <= 1'b0;
            resetreq_q     <= 1'b0;
            linkup_q       <= 1'b0;
            linkupstrobe_q <= 1'b0;
            failed_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            retry_q        <= retry_d;
            start_q        <= bus_io.start;
            // Outputs decode the next state so they line up with state_q.
            resetreq_q     <= (state_d == StReq);
            linkup_q       <= (state_d == StUp);
            linkupstrobe_q <= (state_d == StUp) && (state_q != StUp);
            failed_q       <= (state_d == StFail);
        end
    end

    assign bus_io.resetreq     = resetreq_q;
    assign bus_io.linkup       = linkup_q;
    assign bus_io.linkupstrobe = linkupstrobe_q;
    assign bus_io.failed       = failed_q;
    assign bus_io.retrycnt     = retry_q;
    assign bus_io.state        = state_q;

endmodule

// File: tb/tb_gt_link_watchdog.sv
module tb_gt_link_watchdog;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gt_link_watchdog_if bus ();

    gt_link_watchdog #(
        .REQLENGTH    (4),
        .DONETIMEOUT  (20),
        .ALIGNTIMEOUT (40),
        .STABLELENGTH (8),
        .LOSSLENGTH   (4),
        .BACKOFF      (6),
        .MAXRETRY     (2),
        .CNTWIDTH     (16)
    ) dut (
        .stableclk (clk),
        .resetn    (resetn),
        .bus_io    (bus)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start           = 1'b0;
        bus.resetdone       = 1'b0;
        bus.resetdonestrobe = 1'b0;
        bus.aligned         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    // start high for one cycle t0; returns in cycle t0+1
    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        step();
        step();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
        n_cmp++; if (bus.resetreq !== 1'b0) begin n_err++; $display("FAIL rst_resetreq: got %b want 0", bus.resetreq); end
        n_cmp++; if (bus.linkup !== 1'b0) begin n_err++; $display("FAIL rst_linkup: got %b want 0", bus.linkup); end
        n_cmp++; if (bus.linkupstrobe !== 1'b0) begin n_err++; $display("FAIL rst_linkupstrobe: got %b want 0", bus.linkupstrobe); end
        n_cmp++; if (bus.failed !== 1'b0) begin n_err++; $display("FAIL rst_failed: got %b want 0", bus.failed); end
        n_cmp++; if (bus.retrycnt !== 8'd0) begin n_err++; $display("FAIL rst_retrycnt: got %0d want 0", bus.retrycnt); end
        resetn = 1'b1;
        step();
        // stray strobe outside WAITDONE does nothing
        bus.resetdone       = 1'b1;
        bus.resetdonestrobe = 1'b1;
        step();
        bus.resetdonestrobe = 1'b0;
        step();
        n_cmp++; if (bus.state !== 3'd0) begin n_err++; $display("FAIL idle_strobe_state: got %0d want 0", bus.state); end
    endtask

    task automatic test_nominal_and_loss();
        do_reset();
        pulse_start();
        n_cmp++; if (bus.resetreq !== 1'b0) begin n_err++; $display("FAIL nom_req_t1: got %b want 0", bus.resetreq); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (bus.resetreq !== 1'b1 || bus.state !== 3'd1) begin n_err++; $display("FAIL nom_req_burst%0d: got req=%b st=%0d want req=1 st=1", i, bus.resetreq, bus.state); end
        end
        step();
        n_cmp++; if (bus.resetreq !== 1'b0 || bus.state !== 3'd2) begin n_err++; $display("FAIL nom_req_end: got req=%b st=%0d want req=0 st=2", bus.resetreq, bus.state); end
        repeat (9) step();
        bus.resetdone       = 1'b1;
        bus.resetdonestrobe = 1'b1;
        step();
        bus.resetdonestrobe = 1'b0;
        bus.aligned         = 1'b1;
        n_cmp++; if (bus.state !== 3'd3) begin n_err++; $display("FAIL nom_waitalign: got %0d want 3", bus.state); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.linkup !== 1'b0) begin n_err++; $display("FAIL nom_early_linkup%0d: got %b want 0", i, bus.linkup); end
            step();
        end
        n_cmp++; if (bus.linkup !== 1'b1 || bus.linkupstrobe !== 1'b1) begin n_err++; $display("FAIL nom_up_entry: got up=%b stb=%b want 1 1", bus.linkup, bus.linkupstrobe); end
        n_cmp++; if (bus.retrycnt !== 8'd0 || bus.state !== 3'd4) begin n_err++; $display("FAIL nom_up_status: got rc=%0d st=%0d want 0 4", bus.retrycnt, bus.state); end
        step();
        n_cmp++; if (bus.linkupstrobe !== 1'b0 || bus.linkup !== 1'b1) begin n_err++; $display("FAIL nom_up_hold: got up=%b stb=%b want 1 0", bus.linkup, bus.linkupstrobe); end

        // three misaligned cycles: below the loss threshold
        bus.aligned = 1'b0;
        repeat (3) step();
        bus.aligned = 1'b1;
        step();
        n_cmp++; if (bus.linkup !== 1'b1 || bus.state !== 3'd4) begin n_err++; $display("FAIL loss_short: got up=%b st=%0d want 1 4", bus.linkup, bus.state); end

        // four misaligned cycles: link loss
        bus.aligned = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.linkup !== 1'b1) begin n_err++; $display("FAIL loss_hold%0d: got %b want 1", i, bus.linkup); end
        end
        step();
        n_cmp++; if (bus.linkup !== 1'b0 || bus.state !== 3'd5 || bus.retrycnt !== 8'd1) begin n_err++; $display("FAIL loss_drop: got up=%b st=%0d rc=%0d want 0 5 1", bus.linkup, bus.state, bus.retrycnt); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (bus.resetreq !== 1'b0 || bus.state !== 3'd5) begin n_err++; $display("FAIL loss_backoff%0d: got req=%b st=%0d want 0 5", i, bus.resetreq, bus.state); end
        end
        step();
        n_cmp++; if (bus.resetreq !== 1'b1 || bus.state !== 3'd1) begin n_err++; $display("FAIL loss_rereq: got req=%b st=%0d want 1 1", bus.resetreq, bus.state); end
    endtask

    task automatic test_stale_done();
        do_reset();
        bus.resetdone = 1'b1;
        pulse_start();
        repeat (5) step();
        n_cmp++; if (bus.state !== 3'd2) begin n_err++; $display("FAIL stale_wd_entry: got %0d want 2", bus.state); end
        for (int i = 0; i < 19; i++) begin
            step();
            n_cmp++; if (bus.state !== 3'd2) begin n_err++; $display("FAIL stale_wd_hold%0d: got %0d want 2", i, bus.state); end
        end
        step();
        n_cmp++; if (bus.state !== 3'd5 || bus.retrycnt !== 8'd1) begin n_err++; $display("FAIL stale_retry: got st=%0d rc=%0d want 5 1", bus.state, bus.retrycnt); end
        repeat (5) step();
        n_cmp++; if (bus.resetreq !== 1'b0) begin n_err++; $display("FAIL stale_backoff_req: got %b want 0", bus.resetreq); end
        step();
        n_cmp++; if (bus.resetreq !== 1'b1 || bus.state !== 3'd1) begin n_err++; $display("FAIL stale_second_burst: got req=%b st=%0d want 1 1", bus.resetreq, bus.state); end
    endtask

    task automatic test_exhaustion();
        int   n;
        int   bursts;
        logic prev;
        do_reset();
        pulse_start();
        n      = 0;
        bursts = 0;
        prev   = bus.resetreq;
        while (bus.failed !== 1'b1 && n < 200) begin
            step();
            n++;
            if (bus.resetreq === 1'b1 && prev !== 1'b1) bursts++;
            prev = bus.resetreq;
        end
        n_cmp++; if (n !== 85) begin n_err++; $display("FAIL exh_fail_time: got %0d want 85", n); end
        n_cmp++; if (bursts !== 3) begin n_err++; $display("FAIL exh_bursts: got %0d want 3", bursts); end
        n_cmp++; if (bus.retrycnt !== 8'd2 || bus.state !== 3'd6) begin n_err++; $display("FAIL exh_status: got rc=%0d st=%0d want 2 6", bus.retrycnt, bus.state); end
        repeat (10) step();
        n_cmp++; if (bus.failed !== 1'b1 || bus.resetreq !== 1'b0) begin n_err++; $display("FAIL exh_hold: got f=%b req=%b want 1 0", bus.failed, bus.resetreq); end
        pulse_start();
        step();
        n_cmp++; if (bus.failed !== 1'b0 || bus.retrycnt !== 8'd0 || bus.resetreq !== 1'b1) begin n_err++; $display("FAIL exh_restart: got f=%b rc=%0d req=%b want 0 0 1", bus.failed, bus.retrycnt, bus.resetreq); end
    endtask

    task automatic test_align_glitch();
        do_reset();
        pulse_start();
        repeat (5) step();
        bus.resetdonestrobe = 1'b1;
        step();
        bus.resetdonestrobe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.aligned = (i != 7);
            n_cmp++; if (bus.linkup !== 1'b0) begin n_err++; $display("FAIL glitch_early%0d: got %b want 0", i, bus.linkup); end
            step();
        end
        n_cmp++; if (bus.linkup !== 1'b1 || bus.linkupstrobe !== 1'b1) begin n_err++; $display("FAIL glitch_up: got up=%b stb=%b want 1 1", bus.linkup, bus.linkupstrobe); end
    endtask

    task automatic test_priority_and_reset();
        do_reset();
        pulse_start();
        repeat (53) step();
        n_cmp++; if (bus.state !== 3'd2 || bus.retrycnt !== 8'd1) begin n_err++; $display("FAIL prio_pre: got st=%0d rc=%0d want 2 1", bus.state, bus.retrycnt); end
        pulse_start();
        step();
        n_cmp++; if (bus.state !== 3'd1 || bus.retrycnt !== 8'd0 || bus.resetreq !== 1'b1) begin n_err++; $display("FAIL prio_start_wins: got st=%0d rc=%0d req=%b want 1 0 1", bus.state, bus.retrycnt, bus.resetreq); end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (bus.resetreq !== 1'b0 || bus.state !== 3'd0) begin n_err++; $display("FAIL async_reset: got req=%b st=%0d want 0 0", bus.resetreq, bus.state); end
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_nominal_and_loss();
        test_stale_done();
        test_exhaustion();
        test_align_glitch();
        test_priority_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
